// File: rtl/prog_loader.sv
// Stream-to-memory program loader for the VeriRISC CPU.
// Writes a byte stream into program memory and verifies a trailing checksum.
module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wr_q, mem_wr_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              hs;
    logic              len_ok;
    logic [ADDR_W:0]   count_inc;
    logic [DATA_W-1:0] sum_add;

    assign hs        = in_valid && in_ready_q;
    assign len_ok    = (len != '0) && (len <= DEPTH_L);
    assign count_inc = count_q + 1'b1;
    assign sum_add   = sum_q + in_data;

    // Next-state, datapath updates and registered output decode.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        len_d      = len_q;
        sum_d      = sum_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wr_d   = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (hs) begin
                    mem_addr_d = count_q[ADDR_W-1:0];
                    mem_data_d = in_data;
                    mem_wr_d   = 1'b1;
                    count_d    = count_inc;
                    sum_d      = sum_add;
                    if (count_inc == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (hs) begin
                    state_d = (sum_add == '0) ? S_DONE : S_ERR;
                end
            end
            default: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = S_LOAD;
                        len_d   = len;
                        count_d = '0;
                        sum_d   = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
        endcase
        in_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    // State and output registers; reset returns to IDLE with the CPU held.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wr_q   <= 1'b0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wr_q   <= mem_wr_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wr   = mem_wr_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
